// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch stage and
// the instruction memory port: same-cycle hits, single-word fill with forward on miss.
module icache_responder #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        ramREN,
    output logic [31:0] ramaddr,
    input  logic [31:0] ramload,
    input  logic        ramwait,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state;
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [31:0]        data_mem [SETS];
    logic [31:0]        miss_addr;

    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   miss_idx;
    logic [TAG_W-1:0]   tag;
    logic [TAG_W-1:0]   miss_tag;
    logic               lookup_hit;
    logic               fill_done;
    logic               forward_ok;
    logic               addr_lsb_unused;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    // Byte offset of the PC is irrelevant for word fetches.
    assign addr_lsb_unused = ^iaddr[1:0];

    assign idx        = iaddr[IDX_W+1:2];
    assign tag        = iaddr[31:IDX_W+2];
    assign miss_idx   = miss_addr[IDX_W+1:2];
    assign miss_tag   = miss_addr[31:IDX_W+2];
    assign lookup_hit = valid[idx] && (tag_mem[idx] == tag);
    assign fill_done  = (state == FILL) && !ramwait;
    assign forward_ok = iREN && (iaddr[31:2] == miss_addr[31:2]) && !flush;

    assign ramREN  = (state == FILL) && !RST;
    assign ramaddr = miss_addr;

    always_comb begin
        ihit  = 1'b0;
        iload = data_mem[idx];
        if (!RST) begin
            case (state)
                IDLE: ihit = iREN && lookup_hit;
                FILL: begin
                    iload = ramload;
                    ihit  = !ramwait && forward_ok;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            miss_addr  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iREN && lookup_hit)
                        hit_count <= sat_inc(hit_count);
                    if (iREN && !lookup_hit) begin
                        miss_addr  <= {iaddr[31:2], 2'b00};
                        miss_count <= sat_inc(miss_count);
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (!ramwait) begin
                        valid[miss_idx] <= 1'b1;
                        state           <= IDLE;
                    end
                end
            endcase
            // A flush overrides a fill completing on the same edge.
            if (flush)
                valid <= '0;
        end
    end

    // Arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge CLK) begin
        if (!RST && fill_done) begin
            data_mem[miss_idx] <= ramload;
            tag_mem[miss_idx]  <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder (SETS=16): fills, waits, conflicts,
// redirects, flush races, counter saturation and reset during a fill.
module tb_icache_responder;
    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] iload;
    logic        ramREN;
    logic [31:0] ramaddr;
    logic [31:0] ramload;
    logic        ramwait;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    icache_responder #(.SETS(16)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .flush(flush),
        .ihit(ihit), .iload(iload), .ramREN(ramREN), .ramaddr(ramaddr),
        .ramload(ramload), .ramwait(ramwait),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    // Drive a cycle's inputs on the falling edge, settle, then let checks sample.
    task automatic cyc(input logic ren, input logic [31:0] addr, input logic wt,
                       input logic [31:0] ld, input logic fl);
        @(negedge CLK);
        iREN = ren; iaddr = addr; ramwait = wt; ramload = ld; flush = fl;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Miss in IDLE, then zero-wait fill forwarded to the fetch stage.
    task automatic miss_fill(input string name, input logic [31:0] addr, input logic [31:0] word);
        cyc(1'b1, addr, 1'b0, 32'h0BAD_0BAD, 1'b0);
        chk({name, "_miss_ihit"}, {31'd0, ihit}, 32'd0);
        cyc(1'b1, addr, 1'b0, word, 1'b0);
        chk({name, "_ramren"}, {31'd0, ramREN}, 32'd1);
        chk({name, "_ramaddr"}, ramaddr, addr);
        chk({name, "_fwd_ihit"}, {31'd0, ihit}, 32'd1);
        chk({name, "_fwd_iload"}, iload, word);
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b0; iaddr = '0; flush = 1'b0; ramload = '0; ramwait = 1'b0;
        cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_ramren", {31'd0, ramREN}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        RST = 1'b0;
        #1;
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        chk("rst_idle_ramren", {31'd0, ramREN}, 32'd0);

        // First fetch at 0: miss, forward, then array hit.
        cyc(1'b1, 32'h0, 1'b0, 32'h2001_0005, 1'b0);
        chk("t1_c0_ihit", {31'd0, ihit}, 32'd0);
        chk("t1_c0_ramren", {31'd0, ramREN}, 32'd0);
        cyc(1'b1, 32'h0, 1'b0, 32'h2001_0005, 1'b0);
        chk("t1_c1_ramren", {31'd0, ramREN}, 32'd1);
        chk("t1_c1_ramaddr", ramaddr, 32'h0);
        chk("t1_c1_ihit", {31'd0, ihit}, 32'd1);
        chk("t1_c1_iload", iload, 32'h2001_0005);
        cyc(1'b1, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        chk("t1_c2_ihit", {31'd0, ihit}, 32'd1);
        chk("t1_c2_iload", iload, 32'h2001_0005);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t1_hits", hit_count, 32'd1);
        chk("t1_misses", miss_count, 32'd1);

        // Miss at 0x40 with three wait cycles.
        cyc(1'b1, 32'h40, 1'b1, 32'h1111_1111, 1'b0);
        chk("t2_miss_ihit", {31'd0, ihit}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h40, 1'b1, 32'h1111_1111, 1'b0);
            chk("t2_wait_ramren", {31'd0, ramREN}, 32'd1);
            chk("t2_wait_ramaddr", ramaddr, 32'h40);
            chk("t2_wait_ihit", {31'd0, ihit}, 32'd0);
        end
        cyc(1'b1, 32'h40, 1'b0, 32'h1111_1111, 1'b0);
        chk("t2_done_ramren", {31'd0, ramREN}, 32'd1);
        chk("t2_done_ramaddr", ramaddr, 32'h40);
        chk("t2_done_ihit", {31'd0, ihit}, 32'd1);
        chk("t2_done_iload", iload, 32'h1111_1111);

        // 0x40 evicted 0x0 (both index 0); then conflict on index 1.
        miss_fill("t3_refill0", 32'h0, 32'h2001_0005);
        miss_fill("t3_fill04", 32'h04, 32'h0404_0404);
        miss_fill("t3_fill44", 32'h44, 32'h4444_4444);
        miss_fill("t3_refill04", 32'h04, 32'h0404_0405);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t3_misses", miss_count, 32'd6);
        chk("t3_hits", hit_count, 32'd1);

        // Redirect 0x100 -> 0x200 during the fill.
        cyc(1'b1, 32'h100, 1'b1, 32'h0, 1'b0);
        chk("t4_miss_ihit", {31'd0, ihit}, 32'd0);
        cyc(1'b1, 32'h200, 1'b0, 32'hAAAA_0100, 1'b0);
        chk("t4_redir_ihit", {31'd0, ihit}, 32'd0);
        chk("t4_redir_ramaddr", ramaddr, 32'h100);
        miss_fill("t4_fill200", 32'h200, 32'hBBBB_0200);
        // 0x200 evicted 0x100; redirect to 0x204 (other index) to see the line land.
        cyc(1'b1, 32'h100, 1'b1, 32'h0, 1'b0);
        chk("t4b_miss_ihit", {31'd0, ihit}, 32'd0);
        cyc(1'b1, 32'h204, 1'b0, 32'hCCCC_0100, 1'b0);
        chk("t4b_redir_ihit", {31'd0, ihit}, 32'd0);
        cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        chk("t4b_hit100_ihit", {31'd0, ihit}, 32'd1);
        chk("t4b_hit100_iload", iload, 32'hCCCC_0100);
        miss_fill("t4b_fill204", 32'h204, 32'h2040_2040);

        // Flush on the completing edge leaves the line invalid.
        cyc(1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
        chk("t5_miss_ihit", {31'd0, ihit}, 32'd0);
        cyc(1'b1, 32'h300, 1'b0, 32'hDDDD_0300, 1'b1);
        chk("t5_flush_ihit", {31'd0, ihit}, 32'd0);
        chk("t5_flush_ramren", {31'd0, ramREN}, 32'd1);
        miss_fill("t5_refill", 32'h300, 32'hDDDD_0300);
        cyc(1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
        chk("t5_hit_ihit", {31'd0, ihit}, 32'd1);
        chk("t5_hit_iload", iload, 32'hDDDD_0300);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t5_hits", hit_count, 32'd3);
        chk("t5_misses", miss_count, 32'd12);

        // Saturation of the hit counter.
        force dut.hit_count = 32'hFFFF_FFFE;
        #1;
        release dut.hit_count;
        #1;
        chk("t6_preload", hit_count, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
            chk("t6_hit_ihit", {31'd0, ihit}, 32'd1);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6_saturated", hit_count, 32'hFFFF_FFFF);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6_held", hit_count, 32'hFFFF_FFFF);

        // Reset during a fill abandons it and clears valids.
        cyc(1'b1, 32'h500, 1'b1, 32'h0, 1'b0);
        chk("t7_miss_ihit", {31'd0, ihit}, 32'd0);
        cyc(1'b1, 32'h500, 1'b0, 32'h5555_5555, 1'b0);
        RST = 1'b1;
        #1;
        chk("t7_rst_ihit", {31'd0, ihit}, 32'd0);
        chk("t7_rst_ramren", {31'd0, ramREN}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        RST = 1'b0;
        #1;
        chk("t7_hits", hit_count, 32'd0);
        chk("t7_misses", miss_count, 32'd0);
        chk("t7_ramren", {31'd0, ramREN}, 32'd0);
        chk("t7_ramaddr", ramaddr, 32'd0);
        cyc(1'b1, 32'h500, 1'b1, 32'h0, 1'b0);
        chk("t7_500_miss", {31'd0, ihit}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t7_500_ramren", {31'd0, ramREN}, 32'd1);
        RST = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        RST = 1'b0;
        cyc(1'b1, 32'h300, 1'b1, 32'h0, 1'b0);
        chk("t7_300_miss", {31'd0, ihit}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
